gpio_bank: RTL and testbench

Parametrised multi-port GPIO bank for the ATMega32A emulator, replacing fixed two-port GPIO instances with one block of `NUM_PORTS` ports, each `WIDTH` bits wide. Each port has AVR-style DDRx/PORTx/PINx registers on a shared I/O address bus. It adds three features:

- a two-flop PIN input synchroniser;
- pin-change interrupt logic with per-port masks, flags and enables;
- an optional PORT-toggle-on-PIN-write mode.

The block sits between the CPU I/O bus decoder and the board pads/switches/LEDs.

---
 rtl/gpio_bank.sv | 161 ++++++++++++++++
 tb/tb_gpio_bank.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// Multi-port AVR-style GPIO bank: DDR/PORT/PIN/PCMSK per port, shared pin-change
// interrupt flag/enable registers, two-flop input synchroniser and optional PIN-write toggle.
module gpio_bank #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned TOGGLE_EN = 1
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  input  logic                       pud,
  input  logic [NUM_PORTS*WIDTH-1:0] pin_in,
  output logic [NUM_PORTS*WIDTH-1:0] port_out,
  output logic [NUM_PORTS*WIDTH-1:0] ddr_out,
  output logic [NUM_PORTS*WIDTH-1:0] pullup_en,
  output logic [NUM_PORTS-1:0]       irq
);

  localparam int unsigned TOT_W  = NUM_PORTS * WIDTH;
  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned GLOB_A = 4 * NUM_PORTS;

  localparam logic [1:0] SEL_PIN   = 2'd0;
  localparam logic [1:0] SEL_DDR   = 2'd1;
  localparam logic [1:0] SEL_PORT  = 2'd2;
  localparam logic [1:0] SEL_PCMSK = 2'd3;
  localparam logic [1:0] SETTLED   = 2'd3;

  logic [NUM_PORTS-1:0][WIDTH-1:0] r_ddr;
  logic [NUM_PORTS-1:0][WIDTH-1:0] r_port;
  logic [NUM_PORTS-1:0][WIDTH-1:0] r_pcmsk;
  logic [NUM_PORTS-1:0][WIDTH-1:0] r_sync1;
  logic [NUM_PORTS-1:0][WIDTH-1:0] r_sync2;
  logic [NUM_PORTS-1:0][WIDTH-1:0] r_prev;
  logic [NUM_PORTS-1:0]            r_pcifr;
  logic [NUM_PORTS-1:0]            r_pcicr;
  logic [1:0]                      r_settle;

  logic [NUM_PORTS-1:0] w_port_hit;
  logic [1:0]           w_sel;
  logic                 w_pcifr_hit;
  logic                 w_pcicr_hit;
  logic [NUM_PORTS-1:0] w_chg;
  logic                 w_armed;
  logic [NUM_PORTS-1:0] w_set;
  logic [NUM_PORTS-1:0] w_clr_mask;

  // Address decode: upper bits pick the port, low two bits pick the register
  always_comb begin
    w_port_hit  = '0;
    w_sel       = addr[1:0];
    w_pcifr_hit = (addr == ADDR_W'(GLOB_A));
    w_pcicr_hit = (addr == ADDR_W'(GLOB_A + 1));
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      w_port_hit[p] = (addr[ADDR_W-1:2] == IDX_W'(p));
    end
  end

  // Pad input synchroniser plus one history stage for change detection
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= pin_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Holds off flag setting while the synchroniser refills after reset
  always_ff @(posedge clk) begin
    if (clr) begin
      r_settle <= '0;
    end else if (r_settle != SETTLED) begin
      r_settle <= r_settle + 2'd1;
    end
  end

  assign w_armed = (r_settle == SETTLED);

  always_comb begin
    w_chg = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      w_chg[p] = |((r_sync2[p] ^ r_prev[p]) & r_pcmsk[p]);
    end
  end

  assign w_set      = w_chg & {NUM_PORTS{w_armed}};
  assign w_clr_mask = (wr_en && w_pcifr_hit) ? wr_data[NUM_PORTS-1:0] : '0;

  // Per-port register writes; PIN writes toggle PORT when enabled
  always_ff @(posedge clk) begin
    if (clr) begin
      r_ddr   <= '0;
      r_port  <= '0;
      r_pcmsk <= '0;
      r_pcicr <= '0;
    end else if (wr_en) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        if (w_port_hit[p]) begin
          case (w_sel)
            SEL_PIN: begin
              if (TOGGLE_EN != 0) begin
                r_port[p] <= r_port[p] ^ wr_data;
              end
            end
            SEL_DDR:   r_ddr[p]   <= wr_data;
            SEL_PORT:  r_port[p]  <= wr_data;
            SEL_PCMSK: r_pcmsk[p] <= wr_data;
            default:   ;
          endcase
        end
      end
      if (w_pcicr_hit) begin
        r_pcicr <= wr_data[NUM_PORTS-1:0];
      end
    end
  end

  // Flags are write-1-to-clear; a simultaneous set event wins
  always_ff @(posedge clk) begin
    if (clr) begin
      r_pcifr <= '0;
    end else begin
      r_pcifr <= (r_pcifr & ~w_clr_mask) | w_set;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (w_port_hit[p]) begin
        case (w_sel)
          SEL_PIN:   rd_data = r_sync2[p];
          SEL_DDR:   rd_data = r_ddr[p];
          SEL_PORT:  rd_data = r_port[p];
          SEL_PCMSK: rd_data = r_pcmsk[p];
          default:   rd_data = '0;
        endcase
      end
    end
    if (w_pcifr_hit) begin
      rd_data = WIDTH'(r_pcifr);
    end
    if (w_pcicr_hit) begin
      rd_data = WIDTH'(r_pcicr);
    end
  end

  assign port_out  = r_port;
  assign ddr_out   = r_ddr;
  assign pullup_en = ~r_ddr & r_port & {TOT_W{~pud}};
  assign irq       = r_pcifr & r_pcicr;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (toggle-enabled and toggle-disabled instances).
module tb_gpio_bank;

  localparam int unsigned NP = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 5;

  logic              clk;
  logic              clr;
  logic [AW-1:0]     addr;
  logic              wr_en;
  logic [W-1:0]      wr_data;
  logic              pud;
  logic [NP*W-1:0]   pin_in;

  logic [W-1:0]      rd_data;
  logic [NP*W-1:0]   port_out;
  logic [NP*W-1:0]   ddr_out;
  logic [NP*W-1:0]   pullup_en;
  logic [NP-1:0]     irq;

  logic [W-1:0]      nt_rd_data;
  logic [NP*W-1:0]   nt_port_out;
  logic [NP*W-1:0]   nt_ddr_out;
  logic [NP*W-1:0]   nt_pullup_en;
  logic [NP-1:0]     nt_irq;

  int n_checks;
  int n_fail;

  gpio_bank #(.NUM_PORTS(NP), .WIDTH(W), .ADDR_W(AW), .TOGGLE_EN(1)) dut (
    .clk(clk), .clr(clr), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_data(rd_data), .pud(pud), .pin_in(pin_in), .port_out(port_out),
    .ddr_out(ddr_out), .pullup_en(pullup_en), .irq(irq)
  );

  gpio_bank #(.NUM_PORTS(NP), .WIDTH(W), .ADDR_W(AW), .TOGGLE_EN(0)) dut_nt (
    .clk(clk), .clr(clr), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_data(nt_rd_data), .pud(pud), .pin_in(pin_in), .port_out(nt_port_out),
    .ddr_out(nt_ddr_out), .pullup_en(nt_pullup_en), .irq(nt_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [W-1:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    pin_in = '1;
    pud    = 1'b0;
    clr    = 1'b1;
    tick();
    tick();
    n_checks++;
    if (port_out !== 32'h0) begin n_fail++; $display("FAIL reset_port_out: got %h want 00000000", port_out); end
    n_checks++;
    if (ddr_out !== 32'h0) begin n_fail++; $display("FAIL reset_ddr_out: got %h want 00000000", ddr_out); end
    n_checks++;
    if (pullup_en !== 32'h0) begin n_fail++; $display("FAIL reset_pullup: got %h want 00000000", pullup_en); end
    n_checks++;
    if (irq !== 4'h0) begin n_fail++; $display("FAIL reset_irq: got %h want 0", irq); end
    clr = 1'b0;
    write_reg(5'd3, 8'hFF);
    write_reg(5'd17, 8'h01);
    addr = 5'd0;
    #1;
    n_checks++;
    if (rd_data !== 8'hFF) begin n_fail++; $display("FAIL reset_pin0_fill: got %h want ff", rd_data); end
    for (int i = 0; i < 6; i++) begin
      addr = 5'd16;
      #1;
      n_checks++;
      if (rd_data !== 8'h00 || irq !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_no_spurious_flag[%0d]: pcifr %h irq %h want 00 0", i, rd_data, irq);
      end
      tick();
    end
  endtask

  task automatic test_ddr_port();
    write_reg(5'd5, 8'h0F);
    write_reg(5'd6, 8'hF0);
    n_checks++;
    if (ddr_out[15:8] !== 8'h0F) begin n_fail++; $display("FAIL ddr1_out: got %h want 0f", ddr_out[15:8]); end
    n_checks++;
    if (port_out[15:8] !== 8'hF0) begin n_fail++; $display("FAIL port1_out: got %h want f0", port_out[15:8]); end
    n_checks++;
    if (pullup_en[15:8] !== 8'hF0) begin n_fail++; $display("FAIL pullup1_pud0: got %h want f0", pullup_en[15:8]); end
    pud = 1'b1;
    #1;
    n_checks++;
    if (pullup_en[15:8] !== 8'h00) begin n_fail++; $display("FAIL pullup1_pud1: got %h want 00", pullup_en[15:8]); end
    pud  = 1'b0;
    addr = 5'd5;
    #1;
    n_checks++;
    if (rd_data !== 8'h0F) begin n_fail++; $display("FAIL ddr1_read: got %h want 0f", rd_data); end
  endtask

  task automatic test_toggle();
    write_reg(5'd10, 8'h55);
    write_reg(5'd8, 8'h0F);
    n_checks++;
    if (port_out[23:16] !== 8'h5A) begin n_fail++; $display("FAIL toggle_on_port2: got %h want 5a", port_out[23:16]); end
    n_checks++;
    if (nt_port_out[23:16] !== 8'h55) begin n_fail++; $display("FAIL toggle_off_port2: got %h want 55", nt_port_out[23:16]); end
  endtask

  task automatic test_pcint();
    write_reg(5'd3, 8'h01);
    write_reg(5'd17, 8'h01);
    pin_in[0] = 1'b0;
    tick();
    n_checks++;
    if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL pcint_irq_edge1: got %b want 0", irq[0]); end
    tick();
    addr = 5'd0;
    #1;
    n_checks++;
    if (irq[0] !== 1'b0 || rd_data !== 8'hFE) begin
      n_fail++;
      $display("FAIL pcint_edge2: irq %b pin0 %h want 0 fe", irq[0], rd_data);
    end
    tick();
    addr = 5'd16;
    #1;
    n_checks++;
    if (irq[0] !== 1'b1 || rd_data !== 8'h01) begin
      n_fail++;
      $display("FAIL pcint_flag_set: irq %b pcifr %h want 1 01", irq[0], rd_data);
    end
    write_reg(5'd16, 8'h01);
    n_checks++;
    if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL pcint_clear: got %b want 0", irq[0]); end
    pin_in[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      addr = 5'd16;
      #1;
      n_checks++;
      if (irq !== 4'h0 || rd_data !== 8'h00) begin
        n_fail++;
        $display("FAIL pcint_unmasked[%0d]: irq %h pcifr %h want 0 00", i, irq, rd_data);
      end
    end
  endtask

  task automatic test_collision();
    pin_in[0] = 1'b1;
    tick();
    tick();
    write_reg(5'd16, 8'h01);
    addr = 5'd16;
    #1;
    n_checks++;
    if (rd_data !== 8'h01 || irq[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_set_wins: pcifr %h irq %b want 01 1", rd_data, irq[0]);
    end
    write_reg(5'd16, 8'h01);
    addr = 5'd16;
    #1;
    n_checks++;
    if (rd_data !== 8'h00 || irq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_second_clear: pcifr %h irq %b want 00 0", rd_data, irq[0]);
    end
  endtask

  task automatic test_unmapped();
    logic [AW-1:0] bad [3];
    bad[0] = 5'd18;
    bad[1] = 5'd19;
    bad[2] = 5'd31;
    for (int i = 0; i < 3; i++) begin
      write_reg(bad[i], 8'hFF);
      addr = bad[i];
      #1;
      n_checks++;
      if (rd_data !== 8'h00) begin n_fail++; $display("FAIL unmapped_read[%0d]: got %h want 00", addr, rd_data); end
    end
    n_checks++;
    if (port_out !== 32'h005A_F000) begin n_fail++; $display("FAIL unmapped_port_out: got %h want 005af000", port_out); end
    n_checks++;
    if (ddr_out !== 32'h0000_0F00) begin n_fail++; $display("FAIL unmapped_ddr_out: got %h want 00000f00", ddr_out); end
    addr = 5'd17;
    #1;
    n_checks++;
    if (rd_data !== 8'h01) begin n_fail++; $display("FAIL unmapped_pcicr: got %h want 01", rd_data); end
    addr = 5'd3;
    #1;
    n_checks++;
    if (rd_data !== 8'h01) begin n_fail++; $display("FAIL unmapped_pcmsk0: got %h want 01", rd_data); end
  endtask

  task automatic test_back_to_back();
    write_reg(5'd14, 8'hA5);
    write_reg(5'd12, 8'hFF);
    n_checks++;
    if (port_out[31:24] !== 8'h5A) begin n_fail++; $display("FAIL b2b_toggle1: got %h want 5a", port_out[31:24]); end
    write_reg(5'd12, 8'h0F);
    write_reg(5'd13, 8'h3C);
    n_checks++;
    if (port_out[31:24] !== 8'h55 || ddr_out[31:24] !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_final: port3 %h ddr3 %h want 55 3c", port_out[31:24], ddr_out[31:24]);
    end
    n_checks++;
    if (pullup_en[31:24] !== 8'h41) begin n_fail++; $display("FAIL b2b_pullup3: got %h want 41", pullup_en[31:24]); end
    n_checks++;
    if (nt_port_out[31:24] !== 8'hA5) begin n_fail++; $display("FAIL b2b_notoggle: got %h want a5", nt_port_out[31:24]); end
  endtask

  task automatic test_mid_reset();
    pin_in[0] = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_flag: got %b want 1", irq[0]); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    addr = 5'd0;
    #1;
    n_checks++;
    if (irq !== 4'h0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_clear: irq %h pin0 %h want 0 00", irq, rd_data);
    end
    n_checks++;
    if (port_out !== 32'h0 || ddr_out !== 32'h0 || pullup_en !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_regs: port %h ddr %h pu %h want 0 0 0", port_out, ddr_out, pullup_en);
    end
    tick();
    addr = 5'd16;
    #1;
    n_checks++;
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL midrst_pcifr: got %h want 00", rd_data); end
    addr = 5'd17;
    #1;
    n_checks++;
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL midrst_pcicr: got %h want 00", rd_data); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr      = 1'b1;
    addr     = '0;
    wr_en    = 1'b0;
    wr_data  = '0;
    pud      = 1'b0;
    pin_in   = '1;
    test_reset();
    test_ddr_port();
    test_toggle();
    test_pcint();
    test_collision();
    test_unmapped();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
